i2c_reg_sequencer: RTL and testbench

Register-level sequencer and two-port arbiter in front of the byte-level `i2c` master. Two requesters submit single-register write or read commands (7-bit device, 8-bit register, 8-bit data). The block grants them round-robin and drives the master's `ena_i2c`/`adrr_r_w`/`byte_2_send` controls, byte by byte, from `end_trans`. It returns read data and a timeout error per command.

---
 rtl/i2c_reg_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// Register-level sequencer for the byte-level i2c master: round-robin arbitration of two
// requesters, single-register write/read sequencing, post-stop bus gaps and timeout abort.
module i2c_reg_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 200_000,
   parameter int unsigned GAP_CYC     = 1_000,
   parameter bit          MSB_FIRST   = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0]      req_rw,
   input  logic [1:0][6:0] req_dev,
   input  logic [1:0][7:0] req_reg,
   input  logic [1:0][7:0] req_wdata,
   output logic            rsp_valid,
   output logic            rsp_id,
   output logic [7:0]      rsp_rdata,
   output logic            rsp_err,
   output logic            busy,
   output logic            ena_i2c,
   output logic [7:0]      adrr_r_w,
   output logic [7:0]      byte_2_send,
   output logic            msb_lsb,
   input  logic            end_trans,
   input  logic [7:0]      byte_received
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [3:0] {
      IDLE, W_DEV, W_REG, W_DATA, GAP_RD, R_DEV, R_DATA, STOP, RESP
   } state_t;

   typedef struct packed {
      logic       id;
      logic       rw;
      logic [6:0] dev;
      logic [7:0] reg_addr;
      logic [7:0] wdata;
   } cmd_t;

   state_t         state_q, state_d;
   cmd_t           cmd_q, cmd_d;
   logic           last_q, last_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [7:0]     rdata_q, rdata_d;
   logic           err_q, err_d;
   logic           gnt;
   logic           timeout;

   logic [1:0]     ready_d;
   logic           ena_d;
   logic [7:0]     adrr_d;
   logic [7:0]     byte_d;
   logic           rsp_valid_d;
   logic           rsp_id_d;
   logic [7:0]     rsp_rdata_d;
   logic           rsp_err_d;
   logic           busy_d;

   assign msb_lsb = MSB_FIRST;

   always_comb begin
      // NOTE: every target gets a default first so no branch can infer a latch.
      state_d     = state_q;
      cmd_d       = cmd_q;
      last_d      = last_q;
      timer_d     = timer_q;
      gap_d       = gap_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      gnt         = 1'b0;
      ready_d     = 2'b00;
      ena_d       = ena_i2c;
      adrr_d      = adrr_r_w;
      byte_d      = byte_2_send;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;

      if (ena_i2c)   timer_d = timer_q + 1'b1;
      if (end_trans) timer_d = '0;

      // An end_trans arriving on the same cycle as expiry still counts as progress.
      timeout = ena_i2c && !end_trans && (timer_q == T_LAST) &&
                (state_q inside {W_DEV, W_REG, W_DATA, R_DEV, R_DATA});

      case (state_q)
         IDLE: begin
            if (req_valid != 2'b00) begin
               gnt            = (req_valid == 2'b11) ? ~last_q : req_valid[1];
               cmd_d.id       = gnt;
               cmd_d.rw       = req_rw[gnt];
               cmd_d.dev      = req_dev[gnt];
               cmd_d.reg_addr = req_reg[gnt];
               cmd_d.wdata    = req_wdata[gnt];
               last_d         = gnt;
               ready_d[gnt]   = 1'b1;
               ena_d          = 1'b1;
               adrr_d         = {req_dev[gnt], 1'b0};
               byte_d         = req_reg[gnt];
               timer_d        = '0;
               rdata_d        = 8'h00;
               err_d          = 1'b0;
               state_d        = W_DEV;
            end
         end
         W_DEV: begin
            if (end_trans) state_d = W_REG;
         end
         W_REG: begin
            if (end_trans) begin
               if (cmd_q.rw) begin
                  ena_d   = 1'b0;
                  gap_d   = '0;
                  state_d = GAP_RD;
               end else begin
                  byte_d  = cmd_q.wdata;
                  state_d = W_DATA;
               end
            end
         end
         W_DATA: begin
            if (end_trans) begin
               ena_d   = 1'b0;
               gap_d   = '0;
               state_d = STOP;
            end
         end
         GAP_RD: begin
            if (gap_q == G_LAST) begin
               ena_d   = 1'b1;
               adrr_d  = {cmd_q.dev, 1'b1};
               timer_d = '0;
               state_d = R_DEV;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         R_DEV: begin
            if (end_trans) state_d = R_DATA;
         end
         R_DATA: begin
            if (end_trans) begin
               rdata_d = byte_received;
               ena_d   = 1'b0;
               gap_d   = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (gap_q == G_LAST) state_d = RESP;
            else                 gap_d   = gap_q + 1'b1;
         end
         RESP: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = cmd_q.id;
            rsp_err_d   = err_q;
            rsp_rdata_d = err_q ? 8'h00 : rdata_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (timeout) begin
         ena_d   = 1'b0;
         err_d   = 1'b1;
         gap_d   = '0;
         state_d = STOP;
      end

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         last_q      <= 1'b1;
         timer_q     <= '0;
         gap_q       <= '0;
         rdata_q     <= 8'h00;
         err_q       <= 1'b0;
         req_ready   <= 2'b00;
         ena_i2c     <= 1'b0;
         adrr_r_w    <= 8'h00;
         byte_2_send <= 8'h00;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_rdata   <= 8'h00;
         rsp_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         last_q      <= last_d;
         timer_q     <= timer_d;
         gap_q       <= gap_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready   <= ready_d;
         ena_i2c     <= ena_d;
         adrr_r_w    <= adrr_d;
         byte_2_send <= byte_d;
         rsp_valid   <= rsp_valid_d;
         rsp_id      <= rsp_id_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: a master BFM answers the byte handshakes while a queue-based
// round-robin model predicts grants, byte streams, gaps and responses.
module tb_i2c_reg_sequencer;

   localparam int TO  = 500;
   localparam int GAP = 20;
   localparam logic [31:0] RST_VEC = {1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

   typedef struct {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] wd;
      logic [7:0] rx;
   } cmd_s;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0]      req_rw;
   logic [1:0][6:0] req_dev;
   logic [1:0][7:0] req_reg;
   logic [1:0][7:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_id;
   logic [7:0]      rsp_rdata;
   logic            rsp_err;
   logic            busy;
   logic            ena_i2c;
   logic [7:0]      adrr_r_w;
   logic [7:0]      byte_2_send;
   logic            msb_lsb;
   logic            end_trans;
   logic [7:0]      byte_received;

   int n_cmp = 0;
   int n_err = 0;
   int model_last;

   i2c_reg_sequencer #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .ena_i2c(ena_i2c), .adrr_r_w(adrr_r_w), .byte_2_send(byte_2_send),
      .msb_lsb(msb_lsb), .end_trans(end_trans), .byte_received(byte_received)
   );

   always #5 clk = ~clk;

   initial begin
      #800_000;
      $display("FAIL watchdog: got no finish, want finish within budget");
      $fatal(1);
   end

   // Round robin: starting after the last winner, the first pending requester wins.
   function automatic int model_pick(input logic [1:0] pend, input int last);
      for (int k = 1; k <= 2; k++)
         if (pend[(last + k) % 2]) return (last + k) % 2;
      return -1;
   endfunction

   function automatic cmd_s rand_cmd(input logic rw);
      cmd_s c;
      c.rw  = rw;
      c.dev = 7'($urandom);
      c.rg  = 8'($urandom);
      c.wd  = 8'($urandom);
      c.rx  = 8'($urandom);
      return c;
   endfunction

   task automatic set_req(input int i, input cmd_s c);
      req_rw[i]    = c.rw;
      req_dev[i]   = c.dev;
      req_reg[i]   = c.rg;
      req_wdata[i] = c.wd;
   endtask

   // Master BFM: waits for ena_i2c, then answers n_end bytes; d0/d1 are byte_2_send after pulses 1/2.
   task automatic serve_phase(input int n_end, input int spacing, input logic [7:0] rx,
                              output logic [7:0] adr, output logic [7:0] d0, output logic [7:0] d1);
      int w = 0;
      adr = 'x; d0 = 'x; d1 = 'x;
      while (ena_i2c !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      if (ena_i2c !== 1'b1) return;
      adr = adrr_r_w;
      for (int k = 1; k <= n_end; k++) begin
         repeat (spacing - 1) @(negedge clk);
         end_trans = 1'b1; byte_received = rx;
         @(negedge clk);
         end_trans = 1'b0; byte_received = 8'($urandom);
         if (k == 1) d0 = byte_2_send;
         if (k == 2) d1 = byte_2_send;
      end
   endtask

   task automatic count_while_ena(input logic lvl, output int cnt);
      cnt = 0;
      while (ena_i2c === lvl && cnt < 5000) begin @(negedge clk); cnt++; end
   endtask

   task automatic count_to_rsp(output int cnt);
      cnt = 0;
      while (rsp_valid !== 1'b1 && cnt < 5000) begin @(negedge clk); cnt++; end
   endtask

   task automatic count_to_ready(output int cnt);
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (req_ready === 2'b00 && cnt < 50);
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b00; req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
      end_trans = 1'b0; byte_received = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++; if ({ena_i2c, adrr_r_w, byte_2_send, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy, msb_lsb} !== RST_VEC) begin n_err++; $display("FAIL reset_vec: got %h want %h", {ena_i2c, adrr_r_w, byte_2_send, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy, msb_lsb}, RST_VEC); end
      rst = 1'b0;
      model_last = 1;
   endtask

   task automatic test_write();
      cmd_s c;
      logic [7:0] adr, d0, d1;
      int cnt;
      c = '{rw: 1'b0, dev: 7'h50, rg: 8'h10, wd: 8'h55, rx: 8'h00};
      set_req(0, c); req_valid = 2'b01;
      count_to_ready(cnt);
      n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL wr_grant_lat: got %0d want 1", cnt); end
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", req_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
      req_valid = 2'b00; model_last = 0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL wr_ready_width: got %b want 00", req_ready); end
      serve_phase(3, 90, 8'h00, adr, d0, d1);
      n_cmp++; if (adr !== 8'hA0) begin n_err++; $display("FAIL wr_adr: got %h want a0", adr); end
      n_cmp++; if (d0 !== 8'h10) begin n_err++; $display("FAIL wr_reg_byte: got %h want 10", d0); end
      n_cmp++; if (d1 !== 8'h55) begin n_err++; $display("FAIL wr_data_byte: got %h want 55", d1); end
      n_cmp++; if (ena_i2c !== 1'b0) begin n_err++; $display("FAIL wr_stop: got ena %b want 0", ena_i2c); end
      count_to_rsp(cnt);
      n_cmp++; if (cnt !== GAP + 1) begin n_err++; $display("FAIL wr_rsp_lat: got %0d want %0d", cnt, GAP + 1); end
      n_cmp++; if ({rsp_id, rsp_err, rsp_rdata} !== 10'h000) begin n_err++; $display("FAIL wr_rsp: got id/err/rdata %b/%b/%h want 0/0/00", rsp_id, rsp_err, rsp_rdata); end
      @(negedge clk);
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL wr_rsp_width: got valid/busy %b/%b want 0/0", rsp_valid, busy); end
   endtask

   task automatic test_read();
      cmd_s c;
      logic [7:0] adr, d0, d1;
      int cnt;
      c = '{rw: 1'b1, dev: 7'h50, rg: 8'h20, wd: 8'($urandom), rx: 8'h3C};
      set_req(1, c); req_valid = 2'b10;
      count_to_ready(cnt);
      n_cmp++; if (cnt !== 1 || req_ready !== 2'b10) begin n_err++; $display("FAIL rd_grant: got lat %0d ready %b want 1 10", cnt, req_ready); end
      req_valid = 2'b00; model_last = 1;
      serve_phase(2, 60, 8'($urandom), adr, d0, d1);
      n_cmp++; if (adr !== 8'hA0) begin n_err++; $display("FAIL rd_adr_w: got %h want a0", adr); end
      n_cmp++; if (d0 !== 8'h20) begin n_err++; $display("FAIL rd_reg_byte: got %h want 20", d0); end
      n_cmp++; if (ena_i2c !== 1'b0) begin n_err++; $display("FAIL rd_phase1_stop: got ena %b want 0", ena_i2c); end
      count_while_ena(1'b0, cnt);
      n_cmp++; if (cnt !== GAP) begin n_err++; $display("FAIL rd_gap: got %0d want %0d", cnt, GAP); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
      serve_phase(2, 60, c.rx, adr, d0, d1);
      n_cmp++; if (adr !== 8'hA1) begin n_err++; $display("FAIL rd_adr_r: got %h want a1", adr); end
      n_cmp++; if (ena_i2c !== 1'b0) begin n_err++; $display("FAIL rd_stop: got ena %b want 0", ena_i2c); end
      count_to_rsp(cnt);
      n_cmp++; if (cnt !== GAP + 1) begin n_err++; $display("FAIL rd_rsp_lat: got %0d want %0d", cnt, GAP + 1); end
      n_cmp++; if ({rsp_id, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h3C}) begin n_err++; $display("FAIL rd_rsp: got id/err/rdata %b/%b/%h want 1/0/3c", rsp_id, rsp_err, rsp_rdata); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h3C) begin n_err++; $display("FAIL rd_rsp_hold: got valid %b rdata %h want 0 3c", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_stray_end();
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         end_trans = 1'b1; byte_received = 8'($urandom);
         @(negedge clk);
         end_trans = 1'b0;
         repeat ($urandom_range(1, 6)) begin
            @(negedge clk);
            seen |= ena_i2c | busy | rsp_valid | (|req_ready);
         end
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL stray_activity: got %b want 0", seen); end
      n_cmp++; if (rsp_rdata !== 8'h3C) begin n_err++; $display("FAIL stray_rsp_hold: got %h want 3c", rsp_rdata); end
   endtask

   task automatic test_timeout();
      cmd_s c;
      logic [7:0] adr, d0, d1;
      int cnt;
      c = rand_cmd(1'b1);
      set_req(0, c); req_valid = 2'b01;
      count_to_ready(cnt);
      n_cmp++; if (cnt !== 1 || req_ready !== 2'b01) begin n_err++; $display("FAIL to_grant: got lat %0d ready %b want 1 01", cnt, req_ready); end
      req_valid = 2'b00; model_last = 0;
      serve_phase(1, 30, 8'h00, adr, d0, d1);
      n_cmp++; if (adr !== {c.dev, 1'b0}) begin n_err++; $display("FAIL to_adr: got %h want %h", adr, {c.dev, 1'b0}); end
      count_while_ena(1'b1, cnt);
      n_cmp++; if (cnt !== TO) begin n_err++; $display("FAIL to_abort_lat: got %0d want %0d", cnt, TO); end
      count_to_rsp(cnt);
      n_cmp++; if (cnt !== GAP + 1) begin n_err++; $display("FAIL to_rsp_lat: got %0d want %0d", cnt, GAP + 1); end
      n_cmp++; if ({rsp_id, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 8'h00}) begin n_err++; $display("FAIL to_rsp: got id/err/rdata %b/%b/%h want 0/1/00", rsp_id, rsp_err, rsp_rdata); end
   endtask

   task automatic test_reset_mid();
      cmd_s c;
      logic [7:0] adr, d0, d1;
      logic seen = 1'b0;
      int cnt;
      c = rand_cmd(1'b0);
      set_req(0, c); req_valid = 2'b01;
      count_to_ready(cnt);
      req_valid = 2'b00;
      serve_phase(2, 20, 8'h00, adr, d0, d1);
      n_cmp++; if (d1 !== c.wd || ena_i2c !== 1'b1) begin n_err++; $display("FAIL rm_in_wdata: got byte %h ena %b want %h 1", d1, ena_i2c, c.wd); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({ena_i2c, adrr_r_w, byte_2_send, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy, msb_lsb} !== RST_VEC) begin n_err++; $display("FAIL rm_reset_vec: got %h want %h", {ena_i2c, adrr_r_w, byte_2_send, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy, msb_lsb}, RST_VEC); end
      rst = 1'b0; model_last = 1;
      repeat (3 * GAP) begin
         @(negedge clk);
         seen |= rsp_valid | ena_i2c | busy;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rm_no_rsp: got %b want 0", seen); end
      c = rand_cmd(1'b0);
      set_req(1, c); req_valid = 2'b10;
      count_to_ready(cnt);
      n_cmp++; if (cnt !== 1 || req_ready !== 2'b10) begin n_err++; $display("FAIL rm_grant: got lat %0d ready %b want 1 10", cnt, req_ready); end
      req_valid = 2'b00; model_last = 1;
      serve_phase(3, 15, 8'h00, adr, d0, d1);
      n_cmp++; if ({adr, d0, d1} !== {c.dev, 1'b0, c.rg, c.wd}) begin n_err++; $display("FAIL rm_bytes: got %h want %h", {adr, d0, d1}, {c.dev, 1'b0, c.rg, c.wd}); end
      count_to_rsp(cnt);
      n_cmp++; if (cnt !== GAP + 1 || {rsp_id, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin n_err++; $display("FAIL rm_rsp: got lat %0d id/err/rdata %b/%b/%h want %0d 1/0/00", cnt, rsp_id, rsp_err, rsp_rdata, GAP + 1); end
   endtask

   // Both requesters hold queued commands; the model predicts each grant and the full exchange.
   task automatic test_contention(input int n_each, input bit mixed);
      cmd_s q0[$], q1[$], c;
      logic [7:0] adr, d0, d1, exp_rd;
      logic [1:0] exp_rdy;
      int cnt, g, sp;
      for (int i = 0; i < n_each; i++) begin
         for (int r = 0; r < 2; r++) begin
            c = rand_cmd(mixed ? 1'($urandom) : 1'b0);
            if (!mixed) c.rg = 8'(r + 1);
            if (r == 0) q0.push_back(c); else q1.push_back(c);
         end
      end
      while (q0.size() + q1.size() > 0) begin
         if (q0.size() > 0) set_req(0, q0[0]);
         if (q1.size() > 0) set_req(1, q1[0]);
         req_valid = {q1.size() > 0, q0.size() > 0};
         g = model_pick(req_valid, model_last);
         exp_rdy = (g == 1) ? 2'b10 : 2'b01;
         count_to_ready(cnt);
         n_cmp++; if (cnt !== 1 || req_ready !== exp_rdy) begin n_err++; $display("FAIL arb_grant: got lat %0d ready %b want 1 %b", cnt, req_ready, exp_rdy); end
         c = (g == 1) ? q1.pop_front() : q0.pop_front();
         model_last = g;
         if (q0.size() > 0) set_req(0, q0[0]);
         if (q1.size() > 0) set_req(1, q1[0]);
         req_valid = {q1.size() > 0, q0.size() > 0};
         @(negedge clk);
         n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL arb_ready_width: got %b want 00", req_ready); end
         sp = $urandom_range(3, 40);
         serve_phase(c.rw ? 2 : 3, sp, c.rx, adr, d0, d1);
         n_cmp++; if (adr !== {c.dev, 1'b0} || d0 !== c.rg) begin n_err++; $display("FAIL arb_hdr: got adr %h reg %h want %h %h", adr, d0, {c.dev, 1'b0}, c.rg); end
         if (!c.rw) begin
            n_cmp++; if (d1 !== c.wd) begin n_err++; $display("FAIL arb_wdata: got %h want %h", d1, c.wd); end
         end else begin
            count_while_ena(1'b0, cnt);
            n_cmp++; if (cnt !== GAP) begin n_err++; $display("FAIL arb_rd_gap: got %0d want %0d", cnt, GAP); end
            serve_phase(2, sp, c.rx, adr, d0, d1);
            n_cmp++; if (adr !== {c.dev, 1'b1}) begin n_err++; $display("FAIL arb_rd_adr: got %h want %h", adr, {c.dev, 1'b1}); end
         end
         count_to_rsp(cnt);
         exp_rd = c.rw ? c.rx : 8'h00;
         n_cmp++; if (cnt !== GAP + 1 || {rsp_id, rsp_err, rsp_rdata} !== {1'(g), 1'b0, exp_rd}) begin n_err++; $display("FAIL arb_rsp: got lat %0d id/err/rdata %b/%b/%h want %0d %0d/0/%h", cnt, rsp_id, rsp_err, rsp_rdata, GAP + 1, g, exp_rd); end
      end
      req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_stray_end();
      test_timeout();
      test_reset_mid();
      test_contention(2, 1'b0);
      test_contention(3, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
